// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: instruction fields, memory ready handshakes, datapath controls and debug state.
// master = control unit, slave = datapath / environment.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int FUNC_W   = 5
);
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]   func;
  // Ready handshake: a memory step completes in the first cycle its ready is 1 while the
  // unit waits in FETCH/MEM; the strobes stay asserted until then, and ready is ignored elsewhere.
  logic                imem_ready;
  logic                dmem_ready;
  logic                pcWrite;
  logic                irWrite;
  logic [1:0]          regDst;
  logic [1:0]          memToReg;
  logic                regWrite;
  logic                memRead;
  logic                memWrite;
  logic                ALUsrc;
  logic                ALUsel;
  logic                branch;
  logic                jumpAddr;
  logic                lblSel;
  logic [4:0]          ALUop;
  logic [2:0]          state;
  logic                fault;
  logic                illegal;

  modport master (
    input  run, opcode, func, imem_ready, dmem_ready,
    output pcWrite, irWrite, regDst, memToReg, regWrite, memRead, memWrite,
           ALUsrc, ALUsel, branch, jumpAddr, lblSel, ALUop, state, fault, illegal
  );

  modport slave (
    output run, opcode, func, imem_ready, dmem_ready,
    input  pcWrite, irWrite, regDst, memToReg, regWrite, memRead, memWrite,
           ALUsrc, ALUsel, branch, jumpAddr, lblSel, ALUop, state, fault, illegal
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle KGPminiRISC control FSM: FETCH/DECODE/EXEC/MEM/WB with ready waits and timeout fault.
// Optional MCU_ILLEGAL_TRAP_EN: an illegal decode parks the unit in TRAP until reset.
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int FUNC_W   = 5,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input logic clk,
  input logic rst,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
  } state_e;

  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BR, C_ILL} cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [4:0] aluop;
    logic       alusrc;
    logic       alusel;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       branch;
    logic       jumpaddr;
    logic       lblsel;
  } dec_t;

  state_e            state_q, state_d, bound;
  dec_t              dec, word_q;
  logic [WAIT_W-1:0] cnt_q;
  logic              cnt_inc, fault_q, fault_set, latch;
  logic [5:0]        op;
  logic [4:0]        fn;
  logic              r_ok, r_src, r_sel, hi_bad;
  logic [4:0]        r_op;

  always_comb begin
    op     = bus.opcode[5:0];
    fn     = bus.func[4:0];
    hi_bad = ((bus.opcode >> 6) != '0) || ((bus.func >> 5) != '0);
    r_ok   = 1'b0;
    r_op   = '0;
    r_src  = 1'b0;
    r_sel  = 1'b0;
    dec    = '0;
    dec.cls = C_ILL;
    case (op)
      6'h00: case (fn)
        5'd0: begin r_ok = 1'b1; r_op = 5'b00001; end
        5'd1: begin r_ok = 1'b1; r_op = 5'b00101; r_sel = 1'b1; end
        default: ;
      endcase
      6'h01: case (fn)
        5'd0: begin r_ok = 1'b1; r_op = 5'b00010; end
        5'd1: begin r_ok = 1'b1; r_op = 5'b00011; end
        default: ;
      endcase
      6'h02: case (fn)
        5'd0: begin r_ok = 1'b1; r_op = 5'b01010; r_src = 1'b1; end
        5'd1: begin r_ok = 1'b1; r_op = 5'b01000; r_src = 1'b1; end
        5'd2: begin r_ok = 1'b1; r_op = 5'b01010; end
        5'd3: begin r_ok = 1'b1; r_op = 5'b01000; end
        5'd4: begin r_ok = 1'b1; r_op = 5'b01001; r_src = 1'b1; end
        5'd5: begin r_ok = 1'b1; r_op = 5'b01001; end
        default: ;
      endcase
      6'h0F: if (fn == 5'd0) begin r_ok = 1'b1; r_op = 5'b00000; end
      6'h03: begin r_ok = 1'b1; r_op = 5'b00001; r_src = 1'b1; end
      6'h04: begin r_ok = 1'b1; r_op = 5'b00101; r_src = 1'b1; r_sel = 1'b1; end
      6'h05: begin
        dec.cls = C_LOAD; dec.aluop = 5'b10101; dec.alusrc = 1'b1;
        dec.regdst = 2'b01; dec.memtoreg = 2'b01; dec.regwrite = 1'b1;
      end
      6'h06: begin dec.cls = C_STORE; dec.aluop = 5'b10101; dec.alusrc = 1'b1; end
      6'h07, 6'h08, 6'h09: begin dec.cls = C_BR; dec.branch = 1'b1; dec.lblsel = 1'b1; end
      6'h0A: begin dec.cls = C_BR; dec.branch = 1'b1; dec.jumpaddr = 1'b1; end
      6'h0B, 6'h0D, 6'h0E: begin dec.cls = C_BR; dec.branch = 1'b1; end
      6'h0C: begin dec.cls = C_BR; dec.branch = 1'b1; dec.regdst = 2'b10; dec.regwrite = 1'b1; end
      default: ;
    endcase
    if (r_ok) begin
      dec.cls = C_ALU; dec.aluop = r_op; dec.alusrc = r_src; dec.alusel = r_sel;
      dec.regwrite = 1'b1; dec.memtoreg = 2'b10;
    end
    if (hi_bad) begin
      dec     = '0;
      dec.cls = C_ILL;
    end
  end

  always_comb begin
    state_d   = state_q;
    bound     = bus.run ? S_FETCH : S_IDLE;
    cnt_inc   = 1'b0;
    fault_set = 1'b0;
    latch     = 1'b0;
    bus.pcWrite = 1'b0; bus.irWrite = 1'b0; bus.regDst = '0; bus.memToReg = '0;
    bus.regWrite = 1'b0; bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.ALUsrc = 1'b0;
    bus.ALUsel = 1'b0; bus.branch = 1'b0; bus.jumpAddr = 1'b0; bus.lblSel = 1'b0;
    bus.ALUop = '0; bus.illegal = 1'b0;
    case (state_q)
      S_IDLE: if (bus.run && !fault_q) state_d = S_FETCH;
      S_FETCH: if (bus.run) begin
        if (bus.imem_ready) begin
          bus.irWrite = 1'b1; bus.pcWrite = 1'b1; state_d = S_DECODE;
        end else if (cnt_q == WAIT_W'(MAX_WAIT)) begin
          fault_set = 1'b1; state_d = S_IDLE;
        end else cnt_inc = 1'b1;
      end
      S_DECODE: begin
        latch = 1'b1;
        if (dec.cls == C_ILL) begin
          bus.illegal = 1'b1;
`ifdef MCU_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end else state_d = S_EXEC;
      end
      S_EXEC: begin
        bus.branch   = word_q.branch;
        bus.jumpAddr = word_q.jumpaddr;
        bus.lblSel   = word_q.lblsel;
        bus.regWrite = word_q.regwrite && (word_q.cls == C_BR);
        case (word_q.cls)
          C_ALU:           state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = bound;
        endcase
      end
      S_MEM: begin
        bus.memRead  = (word_q.cls == C_LOAD);
        bus.memWrite = (word_q.cls == C_STORE);
        if (bus.dmem_ready) state_d = (word_q.cls == C_LOAD) ? S_WB : bound;
        else if (cnt_q == WAIT_W'(MAX_WAIT)) begin
          fault_set = 1'b1; state_d = S_IDLE;
        end else cnt_inc = 1'b1;
      end
      S_WB: begin
        bus.regWrite = word_q.regwrite;
        state_d      = bound;
      end
      S_TRAP: bus.illegal = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // Latched ALU/select fields are visible for the whole datapath part of the instruction.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      bus.ALUop    = word_q.aluop;
      bus.ALUsrc   = word_q.alusrc;
      bus.ALUsel   = word_q.alusel;
      bus.regDst   = word_q.regdst;
      bus.memToReg = word_q.memtoreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) word_q <= dec;
      if (state_d != state_q) cnt_q <= '0;
      else if (cnt_inc)       cnt_q <= cnt_q + 1'b1;
      if (fault_set) fault_q <= 1'b1;
    end
  end

  assign bus.state = state_q;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: decode table, per-instruction cycle schedules from a reference
// model, random instruction streams, and hand sequences for waits, faults, reset and illegal ops.
module tb_multicycle_control_unit;
  localparam int W  = 24;
  localparam int IW = 14;
  localparam int MAXW = 15;
  localparam int ALU = 0, LD = 1, ST = 2, BR = 3, ILL = 4;

  typedef struct {
    logic [5:0] op;
    logic [4:0] fn;
    bit         anyfn;
    int         cls;
    logic [4:0] aop;
    logic       src, sel;
    logic [1:0] rd, mtr;
    logic       rw, br, ja, lbl;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_control_unit_if #(.OPCODE_W(6), .FUNC_W(5)) bus ();
  multicycle_control_unit #(.OPCODE_W(6), .FUNC_W(5), .MAX_WAIT(MAXW), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  ent_t            tbl[$];
  logic [W-1:0]    exp_q[$];
  logic [IW-1:0]   in_q[$];
  int checks = 0, errors = 0;
  int mr_cnt, rw_cnt, il_cnt;
  bit at_idle;

  function automatic ent_t mk(logic [5:0] op, logic [4:0] fn, bit anyfn, int cls, logic [4:0] aop,
                              logic src, logic sel, logic [1:0] rd, logic [1:0] mtr,
                              logic rw, logic br, logic ja, logic lbl);
    ent_t e;
    e.op = op; e.fn = fn; e.anyfn = anyfn; e.cls = cls; e.aop = aop; e.src = src; e.sel = sel;
    e.rd = rd; e.mtr = mtr; e.rw = rw; e.br = br; e.ja = ja; e.lbl = lbl;
    return e;
  endfunction

  function automatic ent_t lookup(logic [5:0] op, logic [4:0] fn);
    foreach (tbl[i]) if (tbl[i].op == op && (tbl[i].anyfn || tbl[i].fn == fn)) return tbl[i];
    return mk(op, fn, 0, ILL, 5'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
  endfunction

  function automatic logic [W-1:0] vec(logic [2:0] st, logic irw, logic pcw, logic rw, logic mr,
      logic mw, logic [1:0] rd, logic [1:0] mtr, logic [4:0] aop, logic src, logic sel,
      logic br, logic ja, logic lbl, logic ill, logic flt);
    return {st, irw, pcw, rw, mr, mw, rd, mtr, aop, src, sel, br, ja, lbl, ill, flt};
  endfunction

  function automatic logic [W-1:0] vst(logic [2:0] st, logic flt);
    return vec(st, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 0, 0, 0, 0, 0, flt);
  endfunction

  function automatic logic [W-1:0] act();
    return {bus.state, bus.irWrite, bus.pcWrite, bus.regWrite, bus.memRead, bus.memWrite,
            bus.regDst, bus.memToReg, bus.ALUop, bus.ALUsrc, bus.ALUsel, bus.branch,
            bus.jumpAddr, bus.lblSel, bus.illegal, bus.fault};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(string nm, logic [W-1:0] a, logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic check_int(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic push(logic run, logic im, logic dm, logic [5:0] op, logic [4:0] fn, logic [W-1:0] e);
    in_q.push_back({run, im, dm, op, fn});
    exp_q.push_back(e);
  endtask

  task automatic push_rnd(logic run, logic im, logic dm, logic [W-1:0] e);
    push(run, im, dm, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), e);
  endtask

  // Expected cycle-by-cycle schedule of one instruction; wi/wd beyond MAXW model a timeout.
  task automatic push_instr(ent_t e, int wi, int wd, bit rm);
    bit r;
    logic [W-1:0] mv;
    r = (e.cls == ILL) ? 1'b1 : rm;
    if (at_idle) push_rnd(1, rb(), rb(), vst(0, 0));
    at_idle = 0;
    if (wi > MAXW) begin
      for (int i = 0; i <= MAXW; i++) push_rnd(1, 0, rb(), vst(1, 0));
      for (int i = 0; i < 3; i++) push_rnd(1, rb(), rb(), vst(0, 1));
      return;
    end
    for (int i = 0; i < wi; i++) push_rnd(1, 0, rb(), vst(1, 0));
    push_rnd(1, 1, rb(), vec(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0));
    push(r, rb(), rb(), e.op, e.fn,
         vec(2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 0, 0, 0, 0, e.cls == ILL, 0));
    if (e.cls == ILL) return;
    push_rnd(r, rb(), rb(), vec(3, 0, 0, e.rw && e.cls == BR, 0, 0, e.rd, e.mtr, e.aop, e.src,
                                e.sel, e.br, e.ja, e.lbl, 0, 0));
    if (e.cls == LD || e.cls == ST) begin
      mv = vec(4, 0, 0, 0, e.cls == LD, e.cls == ST, e.rd, e.mtr, e.aop, e.src, e.sel, 0, 0, 0, 0, 0);
      if (wd > MAXW) begin
        for (int i = 0; i <= MAXW; i++) push_rnd(1, rb(), 0, mv);
        for (int i = 0; i < 3; i++) push_rnd(1, rb(), rb(), vst(0, 1));
        return;
      end
      for (int i = 0; i < wd; i++) push_rnd(r, rb(), 0, mv);
      push_rnd(r, rb(), 1, mv);
    end
    if (e.cls == ALU || e.cls == LD)
      push_rnd(r, rb(), rb(), vec(5, 0, 0, e.rw, 0, 0, e.rd, e.mtr, e.aop, e.src, e.sel, 0, 0, 0, 0, 0));
    if (!r) begin
      push_rnd(0, rb(), rb(), vst(0, 0));
      at_idle = 1;
    end
  endtask

  task automatic run_queue(string nm, int max);
    logic [W-1:0] e;
    int n = 0;
    while (in_q.size() > 0 && n < max) begin
      {bus.run, bus.imem_ready, bus.dmem_ready, bus.opcode, bus.func} = in_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      check($sformatf("%s[%0d]", nm, n), act(), e);
      mr_cnt += int'(bus.memRead);
      rw_cnt += int'(bus.regWrite);
      il_cnt += int'(bus.illegal);
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset(string nm);
    bus.run = 1'b0;
    rst = 1'b1;
    #1;
    check(nm, act(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    at_idle = 1;
    in_q.delete();
    exp_q.delete();
  endtask

  initial begin
    ent_t e;
    tbl.push_back(mk(6'h00, 5'd0, 0, ALU, 5'b00001, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h00, 5'd1, 0, ALU, 5'b00101, 0, 1, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h01, 5'd0, 0, ALU, 5'b00010, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h01, 5'd1, 0, ALU, 5'b00011, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h02, 5'd0, 0, ALU, 5'b01010, 1, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h02, 5'd1, 0, ALU, 5'b01000, 1, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h02, 5'd2, 0, ALU, 5'b01010, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h02, 5'd3, 0, ALU, 5'b01000, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h02, 5'd4, 0, ALU, 5'b01001, 1, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h02, 5'd5, 0, ALU, 5'b01001, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h0F, 5'd0, 0, ALU, 5'b00000, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h03, 5'd0, 1, ALU, 5'b00001, 1, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h04, 5'd0, 1, ALU, 5'b00101, 1, 1, 2'b00, 2'b10, 1, 0, 0, 0));
    tbl.push_back(mk(6'h05, 5'd0, 1, LD,  5'b10101, 1, 0, 2'b01, 2'b01, 1, 0, 0, 0));
    tbl.push_back(mk(6'h06, 5'd0, 1, ST,  5'b10101, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(6'h07, 5'd0, 1, BR,  5'd0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 1));
    tbl.push_back(mk(6'h08, 5'd0, 1, BR,  5'd0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 1));
    tbl.push_back(mk(6'h09, 5'd0, 1, BR,  5'd0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 1));
    tbl.push_back(mk(6'h0A, 5'd0, 1, BR,  5'd0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0));
    tbl.push_back(mk(6'h0B, 5'd0, 1, BR,  5'd0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0));
    tbl.push_back(mk(6'h0C, 5'd0, 1, BR,  5'd0, 0, 0, 2'b10, 2'b00, 1, 1, 0, 0));
    tbl.push_back(mk(6'h0D, 5'd0, 1, BR,  5'd0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0));
    tbl.push_back(mk(6'h0E, 5'd0, 1, BR,  5'd0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0));
    tbl.push_back(mk(6'h02, 5'd7, 0, ILL, 5'd0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(6'h00, 5'd2, 0, ILL, 5'd0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(6'h0F, 5'd1, 0, ILL, 5'd0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(6'h10, 5'd0, 0, ILL, 5'd0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(6'h3F, 5'd0, 0, ILL, 5'd0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));

    bus.run = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    bus.opcode = '0; bus.func = '0;
    @(posedge clk);
    #1;
    check("reset_init", act(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    at_idle = 1;

    // decode table, zero-wait memories, continuous run
    foreach (tbl[i]) begin
`ifdef MCU_ILLEGAL_TRAP_EN
      if (tbl[i].cls == ILL) continue;
`endif
      push_instr(tbl[i], 0, 0, 1);
      run_queue($sformatf("tbl_op%02h_f%0d", tbl[i].op, tbl[i].fn), 1000);
    end

    // load with three not-ready data cycles
    mr_cnt = 0; rw_cnt = 0;
    push_instr(lookup(6'h05, 5'd0), 0, 3, 1);
    run_queue("load_wait", 1000);
    check_int("load_memread_cycles", mr_cnt, 4);
    check_int("load_regwrite_cycles", rw_cnt, 1);

    // run dropped mid-instruction: each completes and parks in IDLE
    push_instr(lookup(6'h01, 5'd1), 0, 0, 0);
    push_instr(lookup(6'h06, 5'd0), 0, 2, 0);
    push_instr(lookup(6'h0B, 5'd0), 0, 0, 0);
    push_instr(lookup(6'h05, 5'd0), 1, 0, 0);
    run_queue("run_low", 1000);

    // ready arriving exactly at the wait limit completes the transfer
    push_instr(lookup(6'h05, 5'd0), MAXW, MAXW, 1);
    push_instr(lookup(6'h06, 5'd0), MAXW, MAXW, 1);
    run_queue("wait_max", 1000);

    for (int k = 0; k < 40; k++) begin
`ifdef MCU_ILLEGAL_TRAP_EN
      do e = tbl[$urandom_range(0, tbl.size() - 1)]; while (e.cls == ILL);
`else
      if ($urandom_range(0, 7) == 0) e = lookup(6'($urandom_range(0, 63)), 5'($urandom_range(0, 7)));
      else e = tbl[$urandom_range(0, tbl.size() - 1)];
`endif
      push_instr(e, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
      run_queue($sformatf("rand%0d_op%02h", k, e.op), 1000);
    end

    // illegal instruction
    rw_cnt = 0; il_cnt = 0;
`ifdef MCU_ILLEGAL_TRAP_EN
    if (at_idle) push_rnd(1, rb(), rb(), vst(0, 0));
    push_rnd(1, 1, rb(), vec(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0));
    push(1, rb(), rb(), 6'h02, 5'd7, vec(2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      push_rnd(rb(), rb(), rb(), vec(6, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0));
    run_queue("illegal_trap", 1000);
    check_int("illegal_cycles", il_cnt, 5);
    do_reset("reset_after_trap");
`else
    push_instr(lookup(6'h02, 5'd7), 0, 0, 1);
    push_instr(lookup(6'h00, 5'd0), 0, 0, 1);
    run_queue("illegal_nop", 1000);
    check_int("illegal_pulses", il_cnt, 1);
    check_int("illegal_regwrite", rw_cnt, 1);
`endif

    // asynchronous reset in the middle of a store's MEM wait
    do_reset("reset_pre_store");
    push_instr(lookup(6'h06, 5'd0), 0, 5, 1);
    run_queue("store_pre_rst", 5);
    #2;
    check_int("store_memwrite_before_rst", int'(bus.memWrite), 1);
    do_reset("reset_mid_store");

    // instruction memory never ready: timeout fault, sticky in IDLE with run=1
    push_instr(lookup(6'h00, 5'd0), MAXW + 1, 0, 1);
    run_queue("fetch_fault", 1000);
    do_reset("reset_clears_fault");

    // data memory never ready
    push_instr(lookup(6'h05, 5'd0), 0, MAXW + 1, 1);
    run_queue("mem_fault", 1000);
    do_reset("reset_after_mem_fault");

    push_instr(lookup(6'h03, 5'd0), 0, 0, 1);
    run_queue("after_fault", 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Sequenced successor to the single-cycle KGPminiRISC decoder. It decodes the same opcode/func encoding and drives the same datapath controls, one datapath step per state. The steps are fetch, decode, execute, memory and writeback. It adds an instruction/data memory ready handshake, a bounded wait counter with fault flag, and a run/stall input. It sits between the instruction register and the multicycle datapath; decoded controls are latched once per instruction.

Parameters:
OPCODE_W, 6, opcode width (encodings below are for 6; upper bits must be zero when wider).
FUNC_W, 5, func width (same zero-extension rule).
MAX_WAIT, 15, maximum consecutive not-ready cycles tolerated in FETCH or MEM before a fault.
WAIT_W, 4, wait counter width; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
run  in  1  permits leaving IDLE/FETCH; 0 holds the block at instruction boundary.
opcode  in  OPCODE_W  instruction opcode, sampled in DECODE.
func  in  FUNC_W  instruction func, sampled in DECODE.
imem_ready  in  1  instruction memory data valid.
dmem_ready  in  1  data memory access complete.
pcWrite, irWrite  out  1 each  PC update / IR load strobes.
regDst, memToReg  out  2 each  register-destination and writeback-source selects.
regWrite, memRead, memWrite, ALUsrc, ALUsel, branch, jumpAddr, lblSel  out  1 each  datapath controls.
ALUop  out  5  ALU function.
state  out  3  current state encoding, for debug.
fault  out  1  sticky memory-timeout flag.
illegal  out  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- Reset (async, any state): state=IDLE, every output 0, latched decode word 0, wait counter 0, fault 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: if run=1 and fault=0, go to FETCH next cycle; otherwise stay.
- FETCH:
  - memRead is not used for instruction fetch.
  - imem_ready=1: irWrite=1 and pcWrite=1 for that cycle only, then go to DECODE.
  - imem_ready=0: wait counter increments.
- DECODE: latch the decode word from opcode/func. Classes and fields:
  - R-ALU, regWrite=1, memToReg=10, ALUsrc=0 unless stated:
    - op00 f0 add: ALUop 00001.
    - op00 f1 comp: ALUop 00101, ALUsel=1.
    - op01 f0 and: ALUop 00010.
    - op01 f1 xor: ALUop 00011.
    - op02 f0 shll: ALUop 01010, ALUsrc=1.
    - op02 f1 shrl: ALUop 01000, ALUsrc=1.
    - op02 f2 shllv: ALUop 01010.
    - op02 f3 shrlv: ALUop 01000.
    - op02 f4 shra: ALUop 01001, ALUsrc=1.
    - op02 f5 shrav: ALUop 01001.
    - op0F f0 diff: ALUop 00000.
  - I-ALU, regWrite=1, memToReg=10, ALUsrc=1:
    - op03 addi: ALUop 00001.
    - op04 compi: ALUop 00101, ALUsel=1.
  - LOAD op05: ALUsrc=1, ALUop 10101, memRead, regDst=01, memToReg=01, regWrite.
  - STORE op06: ALUsrc=1, ALUop 10101, memWrite.
  - BR, branch=1:
    - op07–09: lblSel=1.
    - op0A: jumpAddr=1.
    - op0B, 0D, 0E: plain branch.
    - op0C call: regDst=10, regWrite=1.
  - Any other op/func, or nonzero high bits: ILLEGAL. illegal pulses 1 cycle and the instruction is treated as NOP, going to FETCH.
- Control output timing:
  - ALU-field outputs (ALUop, ALUsrc, ALUsel) are driven from the latched word in EXEC, MEM and WB; they are 0 elsewhere.
  - memRead/memWrite are asserted only in MEM.
  - regWrite is asserted only in WB, or in EXEC for the call (op0C).
  - branch, jumpAddr and lblSel are asserted only in EXEC.
- EXEC transitions:
  - ALU classes go to WB.
  - LOAD and STORE go to MEM.
  - BR strobes for one cycle, then FETCH (if run=1) or IDLE.
- MEM:
  - Hold memRead/memWrite until dmem_ready=1; the wait counter increments while not ready.
  - On ready: LOAD goes to WB; STORE goes to FETCH (if run=1) or IDLE.
- WB: regWrite for one cycle, then FETCH (if run=1) or IDLE.
- Latency with zero-wait memory: branch 3 cycles, ALU 4, store 4, load 5; FETCH to FETCH.
- run=0 mid-instruction: the current instruction completes; it is only sampled at the boundary.
- Wait counter:
  - Clears on every state change.
  - If the count reaches MAX_WAIT while still not ready: set fault, drop all strobes, go to IDLE.
  - fault is cleared only by rst.
- Ready and count reaching MAX_WAIT in the same cycle: ready wins and the transfer completes.

Optional Feature:
MCU_ILLEGAL_TRAP_EN:
- Defined: an ILLEGAL decode goes to TRAP (state=6), asserts illegal continuously with all other strobes 0, and stays until rst.
- Undefined: TRAP is unreachable; illegal is a 1-cycle pulse and the instruction is treated as a NOP.

Test Plan:
1. rst asserted mid-MEM of a store (memWrite=1) -> same cycle memWrite=0, state=0, fault=0.
2. run=1, ready tied 1, opcode=000000 func=00000 -> irWrite@FETCH; ALUop=00001 in EXEC; regWrite=1 exactly in cycle 4; next state=FETCH.
3. opcode=000101, dmem_ready low 3 cycles -> memRead held 4 cycles, regDst=01, memToReg=01, regWrite one cycle after ready; total 8 cycles.
4. opcode=001100 -> in EXEC: branch=1, regWrite=1, regDst=10, single cycle; state returns to FETCH at cycle 4.
5. imem_ready held 0 with MAX_WAIT=15 -> fault=1 after 15 wait cycles, state=IDLE, remains IDLE with run=1.
6. opcode=000010 func=00111 -> illegal pulses once, no regWrite/memWrite. With MCU_ILLEGAL_TRAP_EN: state=6, illegal stays 1 until rst.
